// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined logic unit: op encoding, flag payload, defaults.
package logic_pkg;

    localparam int unsigned DEF_WIDTH  = 64;
    localparam int unsigned DEF_STAGES = 2;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_ORR = 3'b001,
        OP_EOR = 3'b010,
        OP_BIC = 3'b011,
        OP_ORN = 3'b100,
        OP_EON = 3'b101,
        OP_MVN = 3'b110,
        OP_MOV = 3'b111
    } logic_op_t;

    // Flag fields carried alongside the result through the pipe
    typedef struct packed {
        logic flags_valid;
        logic flag_n;
        logic flag_z;
    } flags_t;

    localparam int unsigned FLAGS_W = $bits(flags_t);

endpackage

// File: rtl/logic_stage.sv
// One valid/ready pipeline register; loads whenever it is empty or its contents move on.
module logic_stage #(
    parameter int unsigned DW         = 8,
    parameter bit          CLEAR_DATA = 1'b0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          up_valid,
    output logic          up_ready_c,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    logic load_c;

    assign load_c     = ~dn_valid | dn_ready;
    assign up_ready_c = load_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dn_valid <= 1'b0;
        end else if (load_c) begin
            dn_valid <= up_valid;
        end
    end

    // Only the output stage needs its payload cleared; inner stages are datapath-only
    generate
        if (CLEAR_DATA) begin : g_clr
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dn_data <= '0;
                end else if (load_c && up_valid) begin
                    dn_data <= up_data;
                end
            end
        end else begin : g_noclr
            always_ff @(posedge clk) begin
                if (load_c && up_valid) begin
                    dn_data <= up_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with N/Z flags and collapsing valid/ready stages.
module logic_unit_pipe
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flags_valid
);

    localparam int unsigned PW = WIDTH + FLAGS_W;

    logic_op_t        op_e;
    logic [WIDTH-1:0] res_c;
    flags_t           flags_in_c;
    flags_t           f_out;

    logic [STAGES:0]  vld;
    logic [STAGES:0]  rdy;
    logic [PW-1:0]    dat [STAGES+1];

    // Op decode ahead of stage 1
    always_comb begin
        op_e  = logic_op_t'(op);
        res_c = '0;
        case (op_e)
            OP_AND:  res_c = a & b;
            OP_ORR:  res_c = a | b;
            OP_EOR:  res_c = a ^ b;
            OP_BIC:  res_c = a & ~b;
            OP_ORN:  res_c = a | ~b;
            OP_EON:  res_c = a ^ ~b;
            OP_MVN:  res_c = ~b;
            OP_MOV:  res_c = b;
            default: res_c = '0;
        endcase
    end

    always_comb begin
        flags_in_c             = '0;
        flags_in_c.flags_valid = set_flags;
    end

    assign vld[0]      = in_valid;
    assign dat[0]      = {res_c, flags_in_c};
    assign rdy[STAGES] = out_ready;
    assign in_ready    = reset_n & rdy[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [PW-1:0] ld_c;

            // Flags are formed only on entry to the output stage, from the incoming result
            if (gi == STAGES - 1) begin : g_last
                logic [WIDTH-1:0] r_c;
                flags_t           f_in;
                flags_t           f_c;

                assign r_c  = dat[gi][PW-1:FLAGS_W];
                assign f_in = flags_t'(dat[gi][FLAGS_W-1:0]);

                always_comb begin
                    f_c        = f_in;
                    f_c.flag_n = f_in.flags_valid & r_c[WIDTH-1];
                    f_c.flag_z = f_in.flags_valid & (r_c == '0);
                end

                assign ld_c = {r_c, f_c};
            end else begin : g_mid
                assign ld_c = dat[gi];
            end

            logic_stage #(
                .DW         (PW),
                .CLEAR_DATA (gi == STAGES - 1)
            ) u_stage (
                .clk        (clk),
                .reset_n    (reset_n),
                .up_valid   (vld[gi]),
                .up_ready_c (rdy[gi]),
                .up_data    (ld_c),
                .dn_valid   (vld[gi+1]),
                .dn_ready   (rdy[gi+1]),
                .dn_data    (dat[gi+1])
            );
        end
    endgenerate

    assign out_valid   = vld[STAGES];
    assign result      = dat[STAGES][PW-1:FLAGS_W];
    assign f_out       = flags_t'(dat[STAGES][FLAGS_W-1:0]);
    assign flag_n      = f_out.flag_n;
    assign flag_z      = f_out.flag_z;
    assign flags_valid = f_out.flags_valid;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three instances (1, 2 and 4 stages) on shared stimulus.
module tb_logic_unit_pipe;
    import logic_pkg::*;

    localparam int unsigned W = 64;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sf;
        logic [W-1:0] r;
        logic [2:0]   f;   // {flags_valid, flag_n, flag_z}
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         set_flags = 1'b0;
    logic         out_ready = 1'b1;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [2:0]   ir, ov, fn, fz, fv;
    logic [W-1:0] res [3];

    int total = 0;
    int bad   = 0;
    int lat [3] = '{1, 2, 4};

    vec_t         tv [10];
    logic [W-1:0] exp_q  [$];
    logic [2:0]   expf_q [$];
    int           sent, got, occ, zero_seen;
    logic         acc, emit, stall_prev, sfb;
    logic [W-1:0] r_prev;
    logic [2:0]   f_prev;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[0]),
        .op(op), .a(a), .b(b), .set_flags(set_flags), .out_valid(ov[0]),
        .out_ready(out_ready), .result(res[0]), .flag_n(fn[0]), .flag_z(fz[0]),
        .flags_valid(fv[0])
    );

    logic_unit_pipe #(.WIDTH(W), .STAGES(2)) u_s2 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[1]),
        .op(op), .a(a), .b(b), .set_flags(set_flags), .out_valid(ov[1]),
        .out_ready(out_ready), .result(res[1]), .flag_n(fn[1]), .flag_z(fz[1]),
        .flags_valid(fv[1])
    );

    logic_unit_pipe #(.WIDTH(W), .STAGES(4)) u_s4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[2]),
        .op(op), .a(a), .b(b), .set_flags(set_flags), .out_valid(ov[2]),
        .out_ready(out_ready), .result(res[2]), .flag_n(fn[2]), .flag_z(fz[2]),
        .flags_valid(fv[2])
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tv[0] = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00FF, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 3'b110};
        tv[1] = '{3'b010, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 3'b101};
        tv[2] = '{3'b110, 64'h0000_0000_0000_1234, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000};
        tv[3] = '{3'b000, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1, 64'hF000_F000_F000_F000, 3'b110};
        tv[4] = '{3'b001, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0100, 1'b1, 64'h0000_0000_0000_0101, 3'b100};
        tv[5] = '{3'b100, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0, 3'b101};
        tv[6] = '{3'b101, 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b110};
        tv[7] = '{3'b111, 64'h0000_0000_0000_ABCD, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 3'b110};
        tv[8] = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 3'b101};
        tv[9] = '{3'b011, 64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 1'b0, 64'h0000_4567_0000_CDEF, 3'b000};

        // Reset state
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_in_ready_s%0d", lat[i]), W'(ir[i]), W'(0));
            chk($sformatf("rst_out_valid_s%0d", lat[i]), W'(ov[i]), W'(0));
            chk($sformatf("rst_result_s%0d", lat[i]), res[i], W'(0));
            chk($sformatf("rst_flags_s%0d", lat[i]), W'({fv[i], fn[i], fz[i]}), W'(0));
        end
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("rst_release_ready", W'(ir), W'(3'b111));
        @(posedge clk);
        #1;

        // Directed vectors, one at a time, latency observed on every depth
        for (int v = 0; v < 10; v++) begin
            in_valid  = 1'b1;
            op        = tv[v].op;
            a         = tv[v].a;
            b         = tv[v].b;
            set_flags = tv[v].sf;
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", v), W'(ir), W'(3'b111));
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            op        = 3'($urandom);
            a         = {$urandom, $urandom};
            b         = {$urandom, $urandom};
            set_flags = 1'($urandom);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("v%0d_valid_s%0d_k%0d", v, lat[i], k), W'(ov[i]), W'(lat[i] == k));
                    if (lat[i] == k) begin
                        chk($sformatf("v%0d_result_s%0d", v, lat[i]), res[i], tv[v].r);
                        chk($sformatf("v%0d_flags_s%0d", v, lat[i]), W'({fv[i], fn[i], fz[i]}), W'(tv[v].f));
                    end
                end
                @(posedge clk);
                #1;
            end
        end

        // Continuous stream with out_ready held high: one per cycle, fixed latency
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            in_valid  = (n <= 8);
            op        = 3'b111;
            a         = {$urandom, $urandom};
            b         = W'(n);
            set_flags = 1'b0;
            #1;
            if (n <= 8) chk($sformatf("stream_ready_n%0d", n), W'(ir), W'(3'b111));
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                int j;
                j = n - lat[i];
                chk($sformatf("stream_valid_s%0d_n%0d", lat[i], n), W'(ov[i]), W'((j >= 0) && (j < 8)));
                if ((j >= 0) && (j < 8))
                    chk($sformatf("stream_result_s%0d_n%0d", lat[i], n), res[i], W'(j + 1));
            end
        end

        // Ten back-to-back ops with out_ready low on cycles 3..6 (2-stage instance)
        do_reset();
        sent = 0; got = 0; occ = 0; zero_seen = 0; stall_prev = 1'b0;
        r_prev = '0; f_prev = '0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            in_valid  = (sent < 10);
            op        = 3'b010;
            a         = 64'hA5A5_A5A5_A5A5_A5A5;
            b         = W'(sent + 1);
            sfb       = 1'(sent);
            set_flags = sfb;
            out_ready = !((c >= 3) && (c <= 6));
            @(negedge clk);
            chk($sformatf("stall_ready_c%0d", c), W'(ir[1]), W'((occ < 2) || out_ready));
            if (!ir[1]) zero_seen++;
            if (stall_prev) begin
                chk($sformatf("stall_hold_valid_c%0d", c), W'(ov[1]), W'(1));
                chk($sformatf("stall_hold_result_c%0d", c), res[1], r_prev);
                chk($sformatf("stall_hold_flags_c%0d", c), W'({fv[1], fn[1], fz[1]}), W'(f_prev));
            end
            acc  = in_valid & ir[1];
            emit = ov[1] & out_ready;
            if (emit) begin
                got++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stall_extra: got result %h want no output", res[1]);
                end else begin
                    chk($sformatf("stall_order_%0d", got), res[1], exp_q.pop_front());
                    chk($sformatf("stall_flags_%0d", got), W'({fv[1], fn[1], fz[1]}), W'(expf_q.pop_front()));
                end
            end
            if (acc) begin
                exp_q.push_back(a ^ b);
                expf_q.push_back({sfb, sfb, 1'b0});
                sent++;
            end
            occ        = occ + int'(acc) - int'(emit);
            stall_prev = ov[1] & !out_ready;
            r_prev     = res[1];
            f_prev     = {fv[1], fn[1], fz[1]};
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stall_got", W'(got), W'(10));
        chk("stall_left", W'(exp_q.size()), W'(0));
        chk("stall_ready_dropped", W'(zero_seen > 0), W'(1));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall_drain_idle_%0d", c), W'(ov[1]), W'(0));
        end

        // Reset asserted with two ops in flight
        do_reset();
        in_valid  = 1'b1;
        op        = 3'b111;
        set_flags = 1'b1;
        b         = W'(7);
        @(posedge clk);
        #1;
        b = W'(8);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("midrst_pre_valid", W'(ov[1]), W'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(ov), W'(0));
        chk("midrst_in_ready", W'(ir), W'(0));
        chk("midrst_result", res[1], W'(0));
        chk("midrst_flags", W'({fv[1], fn[1], fz[1]}), W'(0));
        @(posedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        #1;
        chk("midrst_release_ready", W'(ir), W'(3'b111));
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("midrst_no_output_%0d", c), W'(ov), W'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning operand/result width in bits (legal 8..128).
REQ-002 SHALL have parameter STAGES, default 2, meaning pipeline depth in register stages (legal 1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream offers an operation this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have port op  input  3  operation select, encoding per REQ-014.
REQ-008 SHALL have port a  input  WIDTH  operand A.
REQ-009 SHALL have port b  input  WIDTH  operand B.
REQ-010 SHALL have port set_flags  input  1  request N/Z flag update for this operation.
REQ-011 SHALL have port out_valid  output  1  result, flags and flags_valid are valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result this cycle.
REQ-013 SHALL have ports result (WIDTH), flag_n (1), flag_z (1) and flags_valid (1), all outputs: the registered result, its MSB, its all-zero indication, and the echoed set_flags.

Function
REQ-014 SHALL compute per op: 000 AND a&b; 001 ORR a|b; 010 EOR a^b; 011 BIC a&~b; 100 ORN a|~b; 101 EON a^~b; 110 MVN ~b; 111 MOV b.
REQ-015 SHALL accept an operation exactly on cycles where in_valid and in_ready are both 1.
REQ-016 SHALL present an accepted operation at the output exactly STAGES cycles after acceptance when no stall occurs.
REQ-017 SHALL compute the logic result in stage 1 and compute the flags from the registered result in the last stage; with STAGES=1, both SHALL be computed in stage 1.
REQ-018 SHALL set flag_n = result[WIDTH-1] and flag_z = (result == 0); flags_valid SHALL equal the accepted set_flags, and flag_n/flag_z SHALL be 0 when flags_valid is 0.
REQ-019 SHALL hold a per-stage valid bit; stage k SHALL load from stage k-1 when stage k is empty or stage k is advancing.
REQ-020 SHALL treat the last stage as advancing when out_ready=1 or out_valid=0.
REQ-021 SHALL drive in_ready = 1 when stage 1 is empty or stage 1 advances; bubbles SHALL collapse so a full pipeline with out_ready=0 stalls only when every stage is valid.
REQ-022 SHALL keep result, flags and flags_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL preserve the order of operations, with no loss or duplication, under any out_ready pattern.
REQ-024 SHALL sustain one operation per cycle when out_ready is held at 1.
REQ-025 SHALL allow, on the same cycle, a full pipeline to emit one result and accept one new operation when out_ready=1.
REQ-026 SHALL ignore op, a, b and set_flags on cycles with no acceptance.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously clear all stage valid bits, result, flag_n, flag_z and flags_valid to 0.
REQ-028 SHALL drive in_ready=0 while reset_n=0 and SHALL drive in_ready=1 on the first cycle after deassertion.
REQ-029 SHALL discard in-flight operations if reset is asserted mid-operation; no result SHALL appear after release.
REQ-030 SHALL not require register datapath bits to be reset, except the output registers listed in REQ-027.

Structure
REQ-031 SHALL take the op encoding as a typedef enum (logic_op_t) and the parameter defaults from shared package logic_pkg.
REQ-032 SHALL implement one sub-module, logic_stage, as a single valid/ready pipeline register instantiated STAGES times via generate.
REQ-033 SHALL keep the op decode combinational in the top level, ahead of stage 1.

Verification
REQ-034 SHALL verify with WIDTH=64 and STAGES=2: op=011 with a=FFFF_FFFF_FFFF_FFFF and b=0000_0000_0000_00FF -> result=FFFF_FFFF_FFFF_FF00 two cycles after acceptance.
REQ-035 SHALL verify op=010 with a=b=0123_4567_89AB_CDEF and set_flags=1 -> result=0, flag_z=1, flag_n=0, flags_valid=1.
REQ-036 SHALL verify op=110 with b=0 and set_flags=0 -> result=all-ones, flags_valid=0 and flag_n=flag_z=0.
REQ-037 SHALL verify 10 back-to-back ops with out_ready low on cycles 3-6 -> in_ready=0 only once all stages are full, results in order, none lost or duplicated, and outputs stable during the stall.
REQ-038 SHALL verify reset_n pulsed low with 2 ops in flight -> out_valid=0 immediately, no output after release, and in_ready=1 on the next cycle.
REQ-039 SHALL verify STAGES=1 and STAGES=4 with out_ready=1 over a continuous stream -> throughput of 1 op per cycle and latency of 1 and 4 cycles respectively.
